key_press_classifier: RTL and testbench

- Consumes one raw, active-low, bouncing push-button line.
- Produces the debounced level plus one-cycle event strobes: press, release, short-press, long-press and optional auto-repeat.
- Sits between the board buttons and the control FSMs of the lab projects, for example the operand/step entry of the serial adder.
- Runs on the 12 MHz system clock.

---
 rtl/key_press_classifier_if.sv | 34 +++
 rtl/key_press_classifier.sv | 194 +++++++++++++++++++
 tb/tb_key_press_classifier.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/key_press_classifier_if.sv
// Button-side bundle for key_press_classifier: the raw key input plus the debounced level,
// event strobes and busy flag.
interface key_press_classifier_if;
  logic key;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;

  modport master (
    output key,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  key,
    output key_level,
    output press_pulse,
    output release_pulse,
    output short_pulse,
    output long_pulse,
    output repeat_pulse,
    output busy
  );
endinterface

// File: rtl/key_press_classifier.sv
// Debounces an active-low push button and emits press/release/short/long strobes.
// Define KEY_REPEAT_EN to enable periodic repeat_pulse while the key is long-held.
module key_press_classifier #(
  parameter int unsigned DEB_CYCLES    = 240000,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000,
  parameter int unsigned CW            = 24
) (
  input logic                   clk,
  input logic                   rst,
  key_press_classifier_if.slave kpc
);

  localparam longint unsigned CntRange = 64'd1 << CW;

  if (DEB_CYCLES < 2 || longint'(DEB_CYCLES) >= CntRange ||
      longint'(LONG_CYCLES) >= CntRange || longint'(REPEAT_CYCLES) >= CntRange ||
      LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_press_classifier: illegal parameter combination");
  end

  localparam logic [CW-1:0] DebLast  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LongLast = CW'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RepLast  = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StPressDeb,
    StHeld,
    StLong,
    StRelDeb
  } state_e;

  logic          sync1_q, sync2_q;
  logic          key_s;
  state_e        state_q, state_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_flag_q, long_flag_d;
  logic          key_level_q, key_level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          busy_q;

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= kpc.key;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d   = StPressDeb;
          deb_cnt_d = '0;
        end
      end

      StPressDeb: begin
        if (key_s) begin
          state_d   = StIdle;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d     = StHeld;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
          key_level_d = 1'b1;
          press_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      // Release wins over the long threshold; hold_cnt is frozen on the way out.
      StHeld: begin
        if (key_s) begin
          state_d   = StRelDeb;
          deb_cnt_d = '0;
        end else if (hold_cnt_q == LongLast) begin
          state_d     = StLong;
          hold_cnt_d  = '0;
          long_flag_d = 1'b1;
          long_d      = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      StLong: begin
        if (key_s) begin
          state_d   = StRelDeb;
          deb_cnt_d = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (hold_cnt_q == RepLast) begin
            hold_cnt_d = '0;
            repeat_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`else
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
      end

      StRelDeb: begin
        if (!key_s) begin
          state_d   = long_flag_q ? StLong : StHeld;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d     = StIdle;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          key_level_d = 1'b0;
          release_d   = 1'b1;
          short_d     = ~long_flag_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = StIdle;
        deb_cnt_d  = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign kpc.key_level     = key_level_q;
  assign kpc.press_pulse   = press_q;
  assign kpc.release_pulse = release_q;
  assign kpc.short_pulse   = short_q;
  assign kpc.long_pulse    = long_q;
  assign kpc.repeat_pulse  = repeat_q;
  assign kpc.busy          = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with small counter parameters; strobe counts and
// edge times are checked against hand-computed values.
module tb_key_press_classifier;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Long = 20;
  localparam int unsigned Rep  = 5;
`ifdef KEY_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk;
  logic rst;

  key_press_classifier_if kpc_if ();

  key_press_classifier #(
    .DEB_CYCLES   (Deb),
    .LONG_CYCLES  (Long),
    .REPEAT_CYCLES(Rep),
    .CW           (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kpc(kpc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int edge_n = 0;
  int n_press, n_rel, n_short, n_long, n_rep, n_level;
  int t_press, t_rel, t_short, t_long;
  int t_rep[4];
  int s;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0; n_level = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1;
    for (int i = 0; i < 4; i++) t_rep[i] = -1;
  endtask

  // Advance one edge, then sample 1 time unit later and log any strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (kpc_if.press_pulse)   begin n_press++; t_press = edge_n; end
    if (kpc_if.release_pulse) begin n_rel++;   t_rel   = edge_n; end
    if (kpc_if.short_pulse)   begin n_short++; t_short = edge_n; end
    if (kpc_if.long_pulse)    begin n_long++;  t_long  = edge_n; end
    if (kpc_if.repeat_pulse)  begin
      if (n_rep < 4) t_rep[n_rep] = edge_n;
      n_rep++;
    end
    if (kpc_if.key_level) n_level++;
  endtask

  task automatic run(input logic k, input int n);
    kpc_if.key = k;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int outs();
    return {25'd0, kpc_if.key_level, kpc_if.press_pulse, kpc_if.release_pulse,
            kpc_if.short_pulse, kpc_if.long_pulse, kpc_if.repeat_pulse, kpc_if.busy};
  endfunction

  initial begin
    rst        = 1'b0;
    kpc_if.key = 1'b1;
    clr_stats();
    #1;
    check("reset_outs_async", outs(), 0);
    run(1'b1, 3);
    check("reset_outs_held", outs(), 0);
    rst = 1'b1;
    run(1'b1, 4);
    check("idle_outs", outs(), 0);

    // Clean tap: press edge s+7, release 10 cycles later.
    clr_stats();
    s = edge_n;
    run(1'b0, 10);
    check("tap_busy", kpc_if.busy, 1);
    run(1'b1, 15);
    check("tap_press_cnt", n_press, 1);
    check("tap_press_t", t_press - s, 7);
    check("tap_rel_cnt", n_rel, 1);
    check("tap_rel_t", t_rel - s, 17);
    check("tap_short_cnt", n_short, 1);
    check("tap_short_t", t_short - s, 17);
    check("tap_long_cnt", n_long, 0);
    check("tap_level_cycles", n_level, 10);
    check("tap_end_outs", outs(), 0);

    // Press bounce: press timed from the final falling edge (set at s+3).
    clr_stats();
    s = edge_n;
    run(1'b0, 2);
    run(1'b1, 1);
    run(1'b0, 10);
    run(1'b1, 15);
    check("bnc_press_cnt", n_press, 1);
    check("bnc_press_t", t_press - s, 10);
    check("bnc_rel_t", t_rel - s, 20);
    check("bnc_short_cnt", n_short, 1);

    // Long hold of 40 cycles.
    clr_stats();
    s = edge_n;
    run(1'b0, 40);
    run(1'b1, 15);
    check("long_press_t", t_press - s, 7);
    check("long_cnt", n_long, 1);
    check("long_t", t_long - s, 27);
    check("long_rel_cnt", n_rel, 1);
    check("long_rel_t", t_rel - s, 47);
    check("long_short_cnt", n_short, 0);
    check("long_rep_cnt", n_rep, RepEn ? 3 : 0);
    if (RepEn) begin
      check("long_rep0_t", t_rep[0] - t_long, 5);
      check("long_rep1_t", t_rep[1] - t_long, 10);
      check("long_rep2_t", t_rep[2] - t_long, 15);
    end
    check("long_end_outs", outs(), 0);

    // Release bounce in HELD: hold frozen for 2 cycles, long shifts from s+27 to s+30.
    clr_stats();
    s = edge_n;
    run(1'b0, 10);
    run(1'b1, 2);
    run(1'b0, 30);
    check("rb_rel_none", n_rel, 0);
    check("rb_press_cnt", n_press, 1);
    check("rb_long_cnt", n_long, 1);
    check("rb_long_t", t_long - s, 30);
    run(1'b1, 15);
    check("rb_rel_t", t_rel - s, 49);
    check("rb_short_cnt", n_short, 0);
    check("rb_rep_cnt", n_rep, RepEn ? 2 : 0);

    // Reset while in LONG.
    clr_stats();
    s = edge_n;
    run(1'b0, 30);
    check("rst_long_cnt", n_long, 1);
    check("rst_pre_level", kpc_if.key_level, 1);
    check("rst_pre_busy", kpc_if.busy, 1);
    rst        = 1'b0;
    kpc_if.key = 1'b1;
    #1;
    check("rst_mid_outs", outs(), 0);
    run(1'b1, 2);
    rst = 1'b1;
    clr_stats();
    run(1'b1, 20);
    check("rst_strobes", n_press + n_rel + n_short + n_long + n_rep, 0);
    check("rst_post_outs", outs(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
